// File: rtl/seqdet_sequencer_if.sv
// Host/detector bundle for the sequence-detector sequencer.
// Latency: n/a (signal grouping only).
// Backpressure: none; start is a level request sampled only while the sequencer is idle.
interface seqdet_sequencer_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4,
  parameter int IDX_W = $clog2(WIDTH)
) ();
  localparam int LEN_W = $clog2(WIDTH) + 1;

  logic             start;
  logic [WIDTH-1:0] pattern;
  logic [LEN_W-1:0] len;
  logic             z;
  logic             det_reset;
  logic             w;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] match_count;
  logic             found;
  logic [IDX_W-1:0] first_idx;

  // Sequencer side.
  modport slave (
    input  start, pattern, len, z,
    output det_reset, w, busy, done, match_count, found, first_idx
  );

  // Host / detector side.
  modport master (
    output start, pattern, len, z,
    input  det_reset, w, busy, done, match_count, found, first_idx
  );
endinterface

// File: rtl/seqdet_sequencer.sv
// Clears a two-in-a-row detector, shifts a pattern into it LSB first, and tallies z matches.
// Latency: done pulses L+3 cycles after start is accepted (L = clamped len).
// Backpressure: start is only sampled in IDLE; requests while busy are dropped, not queued.
module seqdet_sequencer #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4,
  parameter int IDX_W = $clog2(WIDTH)
) (
  input  logic clk,
  input  logic reset,
  seqdet_sequencer_if.slave bus
);
  localparam int LEN_W = $clog2(WIDTH) + 1;
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_SHIFT = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] shreg;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] len_clamp;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] sample_bit;
  logic             sample_en;
  logic             last_bit;
  logic [CNT_W-1:0] match_count;
  logic             found;
  logic [IDX_W-1:0] first_idx;

  // Zero or oversize lengths mean "use the whole pattern".
  assign len_clamp = (bus.len == '0 || bus.len > LEN_MAX) ? LEN_MAX : bus.len;
  assign last_bit  = (LEN_W'(idx) == len_q - LEN_W'(1));

  // Next state, plus which pattern bit the current z sample belongs to (z lags w by one cycle).
  always_comb begin
    state_nxt  = state;
    sample_en  = 1'b0;
    sample_bit = '0;
    case (state)
      S_IDLE:  if (bus.start) state_nxt = S_CLEAR;
      S_CLEAR: state_nxt = S_SHIFT;
      S_SHIFT: begin
        sample_en  = (idx != '0);
        sample_bit = idx - IDX_W'(1);
        if (last_bit) state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        sample_en  = 1'b1;
        sample_bit = IDX_W'(len_q - LEN_W'(1));
        state_nxt  = S_DONE;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Pattern shifting, bit index, and match bookkeeping; results persist until the next accepted start.
  always_ff @(posedge clk) begin
    if (reset) begin
      shreg       <= '0;
      len_q       <= '0;
      idx         <= '0;
      match_count <= '0;
      found       <= 1'b0;
      first_idx   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            shreg       <= bus.pattern;
            len_q       <= len_clamp;
            match_count <= '0;
            found       <= 1'b0;
            first_idx   <= '0;
          end
        end
        S_CLEAR: idx <= '0;
        S_SHIFT: begin
          shreg <= shreg >> 1;
          idx   <= idx + IDX_W'(1);
        end
        default: ;
      endcase
      if (sample_en && bus.z) begin
        if (match_count != CNT_MAX) match_count <= match_count + CNT_W'(1);
        if (!found) begin
          found     <= 1'b1;
          first_idx <= sample_bit;
        end
      end
    end
  end

  // The detector is held clear whenever this block is in reset as well as during CLEAR.
  assign bus.det_reset   = reset || (state == S_CLEAR);
  assign bus.w           = (state == S_SHIFT) && shreg[0];
  assign bus.busy        = (state == S_CLEAR) || (state == S_SHIFT) || (state == S_DRAIN);
  assign bus.done        = (state == S_DONE);
  assign bus.match_count = match_count;
  assign bus.found       = found;
  assign bus.first_idx   = first_idx;
endmodule

// File: doc/seqdet_sequencer.md
# seqdet_sequencer

Controller that drives the team's serial two-in-a-row sequence detector (input `w`, Moore output `z`). It clears the detector, shifts a loaded test pattern into it one bit per clock (LSB first), counts the cycles where `z` is high, and records the bit index of the first match. It sits between a register/host interface and one detector instance. It owns the detector's `reset` and `w` inputs.

## Interface
- `WIDTH`, default 8: maximum pattern length in bits; must be at least 2.
- `CNT_W`, default 4: width of the match counter, which saturates.
- `IDX_W`, default `$clog2(WIDTH)`: width of the first-match index.
- `clk` in 1: single clock; all logic is rising-edge.
- `reset` in 1: synchronous, active-high; returns the block to IDLE.
- `start` in 1: run request; sampled only in IDLE.
- `pattern` in WIDTH: bits to shift; bit 0 is shifted first.
- `len` in `$clog2(WIDTH)+1`: number of bits to shift. A value of 0 or greater than WIDTH is clamped to WIDTH.
- `z` in 1: detector output.
- `det_reset` out 1: drives the detector's synchronous reset.
- `w` out 1: drives the detector's serial input.
- `busy` out 1: high from CLEAR through DRAIN.
- `done` out 1: single-cycle pulse in DONE.
- `match_count` out CNT_W: number of `z` highs seen in the last run; saturating.
- `found` out 1: at least one match in the last run.
- `first_idx` out IDX_W: index k of the pattern bit whose absorption first produced `z`=1. Valid only when `found`=1.

## Operation
- States: IDLE, CLEAR, SHIFT, DRAIN, DONE, binary encoded.
- **IDLE**
  - `start`=1: latch `pattern` into the shift register and latch the clamped `len` into `len_q`. Clear `match_count`, `found` and `first_idx`. Go to CLEAR.
  - Otherwise stay in IDLE.
- **CLEAR** (1 cycle): `det_reset`=1, `w`=0. Go to SHIFT with `idx`=0.
- **SHIFT**: `w` = `shreg[0]`. Each cycle, shift `shreg` right and increment `idx`. When `idx` = `len_q`-1, go to DRAIN.
- **DRAIN** (1 cycle): `w`=0. Go to DONE.
- **DONE** (1 cycle): `done`=1. Go to IDLE.
- **`z` sampling**:
  - `z` is sampled in SHIFT cycles with `idx`≥1, and in DRAIN.
  - A sample taken in SHIFT cycle `idx` is credited to bit `idx`-1. A sample taken in DRAIN is credited to bit `len_q`-1.
  - On each `z`=1 sample: `match_count` increments, holding at 2^CNT_W-1. If `found`=0, set `found`=1 and set `first_idx` to the credited bit index.
- `z` is ignored in IDLE, CLEAR and DONE.
- `match_count`, `found` and `first_idx` hold their values from DONE until the next accepted `start`.
- `start` outside IDLE is ignored; there is no queuing.
- `det_reset` = `reset` OR (state==CLEAR), so the detector is also cleared while the block is in reset.
- `w` is 0 in every state except SHIFT.

## Timing
- Reset values:
  - state = IDLE.
  - `busy`=0, `done`=0, `w`=0, `det_reset`=1 (while `reset` is high).
  - `match_count`=0, `found`=0, `first_idx`=0.
- Cycle numbering, with `start` sampled at edge 0:
  - CLEAR occupies cycle 1.
  - SHIFT occupies cycles 2 through L+1, where L = clamped `len`.
  - DRAIN occupies cycle L+2.
  - DONE occupies cycle L+3, with `done` high.
  - IDLE is re-entered at cycle L+4.
- Total run is L+3 cycles from `start` to `done`.
- Earliest next `start` is sampled at the edge ending cycle L+4, i.e. while in IDLE.
- Results are stable and valid during the `done` cycle.
- Reset asserted mid-run: at the next edge, state=IDLE and all results clear. The detector is held in reset for the same cycles. No `done` pulse is produced.
- `reset` and `start` high in the same cycle: `reset` wins.
- `z` sampled as 1 in the same cycle that the counter is at its maximum: the count holds and `found`/`first_idx` update normally.

## Test plan
- All-zeros run: `pattern`=8'h00, `len`=8 -> `done` 11 cycles after `start`; `match_count`=7, `found`=1, `first_idx`=1.
- Alternating pattern: `pattern`=8'h55, `len`=8 -> `match_count`=0, `found`=0. The `w` sequence observed is 1,0,1,0,1,0,1,0.
- Paired bits: `pattern`=8'h33 (LSB-first bits 1,1,0,0,1,1,0,0), `len`=8 -> `match_count`=4, `first_idx`=1.
- Length and clamp:
  - `pattern`=8'hFF, `len`=3 -> `match_count`=2, `done` 6 cycles after `start`.
  - `len`=0 -> run is 8 bits long and `match_count`=7.
- Saturation and ignored start: with CNT_W=2, `pattern`=8'h00, `len`=8 -> `match_count`=3. A `start` pulsed mid-run is ignored and `busy` stays high.
- Reset mid-SHIFT: `reset` asserted at SHIFT `idx`=4 -> next cycle state=IDLE, `match_count`=0, `found`=0, `det_reset`=1, no `done` pulse. A fresh run afterwards gives correct results.
